// File: rtl/menu_countdown_fsm_pkg.sv
// Shared game-flow state codes; the VGA display block decodes the same values.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Also provides a counter-width helper that never returns zero bits.
package menu_countdown_fsm_pkg;

    typedef enum logic [2:0] {
        ST_MENU_P1 = 3'b000,
        ST_MENU_P2 = 3'b001,
        ST_CD3     = 3'b011,
        ST_CD2     = 3'b100,
        ST_CD1     = 3'b101,
        ST_GAME    = 3'b110
    } game_state_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/menu_countdown_fsm_key_conditioner.sv
// Synchronises and debounces one active-low pushbutton, emitting a 1-cycle press pulse.
// Latency: 2 + DEBOUNCE_CYCLES cycles from raw press to pulse. Backpressure: none.
// Releases are debounced the same way but produce no pulse.
module key_conditioner
    import menu_countdown_fsm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;
    logic          settle;

    // The counter only runs while the synced level disagrees with the accepted one,
    // so any bounce back to the accepted level restarts the stability window.
    assign settle = (sync2 != level) && (cnt == CNT_MAX);
    assign press  = settle && !sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (settle) begin
                level <= sync2;
                cnt   <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/menu_countdown_fsm.sv
// Game-flow controller: menu P1/P2 select -> 3-2-1 countdown -> game, driving the VGA state bus.
// Latency: state changes on the clock edge after a conditioned key pulse or timer expiry.
// Backpressure: none; key pulses outside the menu and game_over outside GAME are dropped.
module menu_countdown_fsm
    import menu_countdown_fsm_pkg::*;
#(
    parameter int TICKS_PER_SEC   = 25_000_000,
    parameter int DEBOUNCE_CYCLES = 250_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_sel_n,
    input  logic       key_ok_n,
    input  logic       game_over,
    output logic [2:0] state,
    output logic       two_player,
    output logic       game_start
);

    localparam int TW = cnt_width(TICKS_PER_SEC);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_SEC - 1);

    game_state_t   state_q;
    game_state_t   state_d;
    logic [TW-1:0] sec_q;
    logic [TW-1:0] sec_d;
    logic          two_player_d;
    logic          game_start_d;
    logic          sel_press;
    logic          ok_press;
    logic          sec_done;

    key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_sel_n),
        .press (sel_press)
    );

    key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ok (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_ok_n),
        .press (ok_press)
    );

    assign sec_done = (sec_q == TICK_MAX);
    assign state    = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_MENU_P1;
            sec_q      <= '0;
            two_player <= 1'b0;
            game_start <= 1'b0;
        end else begin
            state_q    <= state_d;
            sec_q      <= sec_d;
            two_player <= two_player_d;
            game_start <= game_start_d;
        end
    end

    // The timer idles at zero outside the countdown, so each digit starts from a clean count.
    always_comb begin
        state_d      = state_q;
        sec_d        = '0;
        two_player_d = two_player;
        game_start_d = 1'b0;
        case (state_q)
            ST_MENU_P1: begin
                if (ok_press) begin
                    state_d      = ST_CD3;
                    two_player_d = 1'b0;
                end else if (sel_press) begin
                    state_d = ST_MENU_P2;
                end
            end
            ST_MENU_P2: begin
                if (ok_press) begin
                    state_d      = ST_CD3;
                    two_player_d = 1'b1;
                end else if (sel_press) begin
                    state_d = ST_MENU_P1;
                end
            end
            ST_CD3: begin
                if (sec_done) state_d = ST_CD2;
                else          sec_d   = sec_q + 1'b1;
            end
            ST_CD2: begin
                if (sec_done) state_d = ST_CD1;
                else          sec_d   = sec_q + 1'b1;
            end
            ST_CD1: begin
                if (sec_done) begin
                    state_d      = ST_GAME;
                    game_start_d = 1'b1;
                end else begin
                    sec_d = sec_q + 1'b1;
                end
            end
            ST_GAME: begin
                if (game_over) state_d = ST_MENU_P1;
            end
            default: state_d = ST_MENU_P1;
        endcase
    end

endmodule

// File: tb/tb_menu_countdown_fsm.sv
// Bench for menu_countdown_fsm with short timing parameters; state transitions are
// checked against a queue of expected (state, cycle) entries queued when keys are driven.
module tb_menu_countdown_fsm;
    import menu_countdown_fsm_pkg::*;

    localparam int TPS = 10;
    localparam int DEB = 4;
    localparam int KEY_LAT = DEB + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_sel_n = 1'b1;
    logic       key_ok_n = 1'b1;
    logic       game_over = 1'b0;
    logic [2:0] state;
    logic       two_player;
    logic       game_start;

    typedef struct {
        logic [2:0] st;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_err = 0;
    int         gs_cnt = 0;
    int         last_chg = 0;
    int         at;
    logic [2:0] prev_state = 3'b000;
    bit         mon_en = 1'b0;

    menu_countdown_fsm #(.TICKS_PER_SEC(TPS), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_sel_n  (key_sel_n),
        .key_ok_n   (key_ok_n),
        .game_over  (game_over),
        .state      (state),
        .two_player (two_player),
        .game_start (game_start)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic expect_at(input logic [2:0] st, input int c);
        exp_q.push_back(exp_t'{st: st, cyc: c});
    endtask

    task automatic key_down(input bit ok, input bit want, input logic [2:0] st, output int chg);
        step();
        if (ok) key_ok_n = 1'b0;
        else    key_sel_n = 1'b0;
        chg = cyc + KEY_LAT;
        if (want) expect_at(st, chg);
    endtask

    task automatic key_up(input bit ok);
        if (ok) key_ok_n = 1'b1;
        else    key_sel_n = 1'b1;
    endtask

    task automatic expect_countdown(input int cd3_at);
        expect_at(ST_CD2, cd3_at + TPS);
        expect_at(ST_CD1, cd3_at + 2 * TPS);
        expect_at(ST_GAME, cd3_at + 3 * TPS);
    endtask

    task automatic pulse_game_over(input bit want);
        step();
        game_over = 1'b1;
        if (want) expect_at(ST_MENU_P1, cyc + 1);
        step();
        game_over = 1'b0;
    endtask

    // Monitor: every state change must match the head of the queue, in value and cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (state !== prev_state) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_change", {29'd0, state}, {29'd0, prev_state});
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("state", {29'd0, state}, {29'd0, mon_e.st});
                    chk("state_cycle", cyc, mon_e.cyc);
                end
                prev_state = state;
                last_chg   = cyc;
            end
            if (game_start === 1'b1) begin
                gs_cnt++;
                chk("gs_state", {29'd0, state}, {29'd0, ST_GAME});
                chk("gs_cycle", cyc, last_chg);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        prev_state = state;
        mon_en = 1'b1;
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_two_player", {31'd0, two_player}, 32'd0);
        chk("rst_game_start", {31'd0, game_start}, 32'd0);

        // 1: idle
        idle(100);
        chk("t1_state", {29'd0, state}, 32'd0);
        chk("t1_gs_cnt", gs_cnt, 0);

        // 2: sel toggles P1 -> P2 -> P1
        key_down(1'b0, 1'b1, ST_MENU_P2, at);
        idle(20);
        key_up(1'b0);
        idle(12);
        chk("t2_p2", {29'd0, state}, {29'd0, ST_MENU_P2});
        key_down(1'b0, 1'b1, ST_MENU_P1, at);
        idle(20);
        key_up(1'b0);
        idle(12);
        chk("t2_p1", {29'd0, state}, {29'd0, ST_MENU_P1});

        // 3: short glitch rejected, then a real confirm from P1
        key_down(1'b1, 1'b0, ST_MENU_P1, at);
        idle(3);
        key_up(1'b1);
        idle(12);
        chk("t3_glitch", {29'd0, state}, {29'd0, ST_MENU_P1});
        key_down(1'b1, 1'b1, ST_CD3, at);
        expect_countdown(at);
        idle(20);
        key_up(1'b1);
        idle(30);
        chk("t3_game", {29'd0, state}, {29'd0, ST_GAME});
        chk("t3_two_player", {31'd0, two_player}, 32'd0);
        pulse_game_over(1'b1);
        idle(12);

        // 4: confirm from P2, keys pressed during the countdown are ignored
        key_down(1'b0, 1'b1, ST_MENU_P2, at);
        idle(20);
        key_up(1'b0);
        idle(12);
        key_down(1'b1, 1'b1, ST_CD3, at);
        expect_countdown(at);
        idle(20);
        key_up(1'b1);
        idle(2);
        key_down(1'b0, 1'b0, ST_MENU_P1, at);
        idle(8);
        key_up(1'b0);
        key_down(1'b1, 1'b0, ST_MENU_P1, at);
        idle(8);
        key_up(1'b1);
        idle(25);
        chk("t4_game", {29'd0, state}, {29'd0, ST_GAME});
        chk("t4_two_player", {31'd0, two_player}, 32'd1);
        chk("t4_gs_cnt", gs_cnt, 2);

        // 5: game_over returns to menu, retained mode; ignored in menu
        pulse_game_over(1'b1);
        idle(2);
        chk("t5_menu", {29'd0, state}, {29'd0, ST_MENU_P1});
        chk("t5_two_player", {31'd0, two_player}, 32'd1);
        pulse_game_over(1'b0);
        idle(5);
        chk("t5_ignored", {29'd0, state}, {29'd0, ST_MENU_P1});

        // 6: async reset in the 5th cycle of CD2
        key_down(1'b0, 1'b1, ST_MENU_P2, at);
        idle(20);
        key_up(1'b0);
        idle(12);
        key_down(1'b1, 1'b1, ST_CD3, at);
        expect_at(ST_CD2, at + TPS);
        while (cyc < at + TPS + 4) step();
        chk("t6_in_cd2", {29'd0, state}, {29'd0, ST_CD2});
        chk("t6_two_player_pre", {31'd0, two_player}, 32'd1);
        #1;
        rst_n = 1'b0;
        expect_at(ST_MENU_P1, cyc);
        #1;
        chk("t6_rst_state", {29'd0, state}, 32'd0);
        chk("t6_rst_two_player", {31'd0, two_player}, 32'd0);
        chk("t6_rst_game_start", {31'd0, game_start}, 32'd0);
        key_up(1'b1);
        idle(3);
        rst_n = 1'b1;
        idle(40);
        chk("t6_after_state", {29'd0, state}, 32'd0);
        chk("t6_gs_cnt", gs_cnt, 2);
        chk("t6_two_player", {31'd0, two_player}, 32'd0);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
